// File: rtl/rxdata_pkg.sv
// Shared constants and types for the rxdata hex-line parser.
// The ASCII codes, state encoding and digit limit live here so that other parsers can reuse them.
package rxdata_pkg;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_X_LO = 8'h78;
    localparam logic [7:0] CH_X_HI = 8'h58;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ZERO   = 2'd1;
    localparam logic [1:0] ST_X      = 2'd2;
    localparam logic [1:0] ST_DIGITS = 2'd3;

    localparam logic [3:0] MAX_DIGITS = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ZERO   = ST_ZERO,
        X      = ST_X,
        DIGITS = ST_DIGITS
    } state_t;

    function automatic logic is_eol(input logic [7:0] ch);
        return (ch == CH_CR) || (ch == CH_LF);
    endfunction

endpackage

// File: rtl/rxdata_hex2nib.sv
// Combinational ASCII hex-digit decoder: 0-9, A-F and a-f map to a nibble plus a valid flag.
module hex2nib (
    input  logic [7:0] i_char,
    output logic [3:0] o_nib,
    output logic       o_valid
);

    logic is_dec;
    logic is_alpha;

    // Letters A-F and a-f both carry 1..6 in the low nibble, so one +9 covers both cases.
    always_comb begin
        is_dec   = (i_char >= 8'h30) && (i_char <= 8'h39);
        is_alpha = ((i_char >= 8'h41) && (i_char <= 8'h46)) ||
                   ((i_char >= 8'h61) && (i_char <= 8'h66));
        o_valid  = is_dec || is_alpha;
        o_nib    = is_alpha ? (i_char[3:0] + 4'd9) : i_char[3:0];
    end

endmodule

// File: rtl/rxdata.sv
// Parses "0x" + 1..8 hex digits + CR/LF from a byte stream into a 32-bit word,
// pulsing o_stb on a complete line and o_err on malformed input or an inter-byte timeout.
module rxdata
    import rxdata_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = 24'd0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    input  logic [7:0]  i_data,
    output logic        o_stb,
    output logic [31:0] o_data,
    output logic        o_err,
    output logic        o_busy
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [3:0]  count_q;
    logic [3:0]  count_d;
    logic [23:0] timer_q;
    logic [23:0] timer_d;
    logic [31:0] data_d;
    logic        stb_d;
    logic        err_d;
    logic        abort;
    logic        timeout_hit;
    logic [3:0]  nib;
    logic        nib_valid;

    hex2nib u_hex2nib (
        .i_char  (i_data),
        .o_nib   (nib),
        .o_valid (nib_valid)
    );

    assign o_busy = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        data_d      = o_data;
        stb_d       = 1'b0;
        err_d       = 1'b0;
        abort       = 1'b0;
        timer_d     = 24'd0;
        timeout_hit = 1'b0;

        // A byte arriving on the expiry cycle wins: expiry only considered when i_stb is low.
        if ((TIMEOUT != 24'd0) && (state_q != IDLE) && !i_stb) begin
            if (timer_q == TIMEOUT - 24'd1) begin
                timeout_hit = 1'b1;
            end else begin
                timer_d = timer_q + 24'd1;
            end
        end

        if (timeout_hit) begin
            abort = 1'b1;
        end else if (i_stb) begin
            case (state_q)
                IDLE: begin
                    if (i_data == CH_ZERO) begin
                        state_d = ZERO;
                    end
                end
                ZERO: begin
                    if ((i_data == CH_X_LO) || (i_data == CH_X_HI)) begin
                        state_d = X;
                    end else begin
                        abort = 1'b1;
                    end
                end
                X: begin
                    if (nib_valid) begin
                        state_d = DIGITS;
                        acc_d   = {28'h0, nib};
                        count_d = 4'd1;
                    end else begin
                        abort = 1'b1;
                    end
                end
                DIGITS: begin
                    if (nib_valid) begin
                        if (count_q < MAX_DIGITS) begin
                            acc_d   = {acc_q[27:0], nib};
                            count_d = count_q + 4'd1;
                        end else begin
                            abort = 1'b1;
                        end
                    end else if (is_eol(i_data)) begin
                        data_d  = acc_q;
                        stb_d   = 1'b1;
                        state_d = IDLE;
                        acc_d   = 32'h0;
                        count_d = 4'd0;
                    end else begin
                        abort = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (abort) begin
            state_d = IDLE;
            err_d   = 1'b1;
            acc_d   = 32'h0;
            count_d = 4'd0;
            timer_d = 24'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            acc_q   <= 32'h0;
            count_q <= 4'd0;
            timer_q <= 24'd0;
            o_data  <= 32'h0;
            o_stb   <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            timer_q <= timer_d;
            o_data  <= data_d;
            o_stb   <= stb_d;
            o_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_rxdata.sv
// Directed bench for rxdata: well-formed lines, full-rate traffic, parse errors, timeout and reset.
module tb_rxdata;

    logic        i_clk;
    logic        i_reset;
    logic        i_stb;
    logic [7:0]  i_data;
    logic        o_stb;
    logic [31:0] o_data;
    logic        o_err;
    logic        o_busy;

    int compared;
    int mismatched;
    int stb_count;
    int err_count;
    int both_count;
    logic [31:0] data_log[$];

    rxdata #(.TIMEOUT(24'd16)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_stb   (i_stb),
        .i_data  (i_data),
        .o_stb   (o_stb),
        .o_data  (o_data),
        .o_err   (o_err),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Pulse observer; outputs are sampled on the falling edge, away from the active edge.
    always @(negedge i_clk) begin
        if (o_stb === 1'b1) begin
            stb_count++;
            data_log.push_back(o_data);
        end
        if (o_err === 1'b1) err_count++;
        if ((o_stb === 1'b1) && (o_err === 1'b1)) both_count++;
    end

    task automatic put(input logic [7:0] b);
        @(negedge i_clk);
        i_stb  = 1'b1;
        i_data = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_stb = 1'b0;
        end
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            put(s[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic send_line(input string s, input logic [7:0] term, input int gap);
        send_str(s, gap);
        put(term);
        idle(3);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_stb   = 1'b0;
        i_data  = 8'h00;
        repeat (3) @(negedge i_clk);
        compared++;
        if (o_stb !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stb got=%b want=0", o_stb); end
        compared++;
        if (o_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err got=%b want=0", o_err); end
        compared++;
        if (o_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_data got=%h want=00000000", o_data); end
        compared++;
        if (o_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got=%b want=0", o_busy); end
        i_reset = 1'b0;
        idle(2);
    endtask

    task automatic test_basic_line();
        int s0, e0;
        s0 = stb_count;
        e0 = err_count;
        send_str("0x12", 1);
        compared++;
        if (o_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_busy got=%b want=1", o_busy); end
        send_line("345678", 8'h0D, 1);
        compared++;
        if (stb_count - s0 !== 1) begin mismatched++; $display("[TB] FAIL basic_stb got=%0d want=1", stb_count - s0); end
        compared++;
        if (err_count - e0 !== 0) begin mismatched++; $display("[TB] FAIL basic_err got=%0d want=0", err_count - e0); end
        compared++;
        if (o_data !== 32'h12345678) begin mismatched++; $display("[TB] FAIL basic_data got=%h want=12345678", o_data); end
        put(8'h0A);
        idle(3);
        compared++;
        if ((stb_count - s0 !== 1) || (err_count - e0 !== 0)) begin
            mismatched++;
            $display("[TB] FAIL stray_lf got stb=%0d err=%0d want stb=1 err=0", stb_count - s0, err_count - e0);
        end
    endtask

    task automatic test_back_to_back();
        int s0, e0;
        s0 = stb_count;
        e0 = err_count;
        send_str("0Xdeadbeef", 0);
        put(8'h0A);
        send_str("0x1F", 0);
        put(8'h0D);
        idle(3);
        compared++;
        if (stb_count - s0 !== 2) begin mismatched++; $display("[TB] FAIL b2b_stb got=%0d want=2", stb_count - s0); end
        compared++;
        if (err_count - e0 !== 0) begin mismatched++; $display("[TB] FAIL b2b_err got=%0d want=0", err_count - e0); end
        if (data_log.size() >= 2) begin
            compared++;
            if (data_log[data_log.size()-2] !== 32'hDEADBEEF) begin
                mismatched++;
                $display("[TB] FAIL b2b_first got=%h want=deadbeef", data_log[data_log.size()-2]);
            end
        end
        compared++;
        if (o_data !== 32'h0000001F) begin mismatched++; $display("[TB] FAIL b2b_second got=%h want=0000001f", o_data); end
    endtask

    task automatic test_overflow();
        int s0;
        s0 = stb_count;
        send_str("0x12345678", 1);
        put("9");
        compared++;
        if (o_err !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_early got=%b want=0", o_err); end
        idle(1);
        compared++;
        if ((o_err !== 1'b1) || (o_stb !== 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL ovf_pulse got err=%b stb=%b want err=1 stb=0", o_err, o_stb);
        end
        compared++;
        if (o_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_busy got=%b want=0", o_busy); end
        idle(1);
        compared++;
        if (o_err !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_width got=%b want=0", o_err); end
        put(8'h0D);
        idle(3);
        compared++;
        if ((stb_count - s0 !== 0) || (o_data !== 32'h0000001F)) begin
            mismatched++;
            $display("[TB] FAIL ovf_nostb got stb=%0d data=%h want stb=0 data=0000001f", stb_count - s0, o_data);
        end
        send_line("0xA", 8'h0D, 1);
        compared++;
        if (o_data !== 32'h0000000A) begin mismatched++; $display("[TB] FAIL ovf_recover got=%h want=0000000a", o_data); end
    endtask

    task automatic test_malformed();
        string bad[3];
        int s0, e0;
        bad[0] = "0y";
        bad[1] = "0x";
        bad[2] = "0x12G";
        for (int k = 0; k < 3; k++) begin
            s0 = stb_count;
            e0 = err_count;
            if (k == 1) send_line(bad[k], 8'h0D, 1);
            else begin
                send_str(bad[k], 1);
                idle(3);
            end
            compared++;
            if ((err_count - e0 !== 1) || (stb_count - s0 !== 0) || (o_busy !== 1'b0) || (o_data !== 32'h0000000A)) begin
                mismatched++;
                $display("[TB] FAIL malformed_%0d got err=%0d stb=%0d busy=%b data=%h want err=1 stb=0 busy=0 data=0000000a",
                         k, err_count - e0, stb_count - s0, o_busy, o_data);
            end
        end
    endtask

    task automatic test_timeout();
        int e0, s0;
        send_str("0x12", 0);
        idle(16);
        compared++;
        if ((o_err !== 1'b0) || (o_busy !== 1'b1)) begin
            mismatched++;
            $display("[TB] FAIL tmo_early got err=%b busy=%b want err=0 busy=1", o_err, o_busy);
        end
        idle(1);
        compared++;
        if ((o_err !== 1'b1) || (o_busy !== 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL tmo_fire got err=%b busy=%b want err=1 busy=0", o_err, o_busy);
        end
        idle(3);
        e0 = err_count;
        s0 = stb_count;
        send_str("0x12", 0);
        idle(15);
        put("3");
        put(8'h0D);
        idle(3);
        compared++;
        if ((err_count - e0 !== 0) || (stb_count - s0 !== 1) || (o_data !== 32'h00000123)) begin
            mismatched++;
            $display("[TB] FAIL tmo_byte_wins got err=%0d stb=%0d data=%h want err=0 stb=1 data=00000123",
                     err_count - e0, stb_count - s0, o_data);
        end
    endtask

    task automatic test_reset_midline();
        int s0, e0;
        send_str("0x12", 1);
        @(negedge i_clk);
        i_reset = 1'b1;
        i_stb   = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b0;
        compared++;
        if (o_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy got=%b want=0", o_busy); end
        compared++;
        if (o_data !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_data got=%h want=00000000", o_data); end
        s0 = stb_count;
        e0 = err_count;
        send_line("34", 8'h0D, 1);
        compared++;
        if ((stb_count - s0 !== 0) || (err_count - e0 !== 0)) begin
            mismatched++;
            $display("[TB] FAIL rst_discard got stb=%0d err=%0d want 0 0", stb_count - s0, err_count - e0);
        end
        send_line("0x34", 8'h0D, 1);
        compared++;
        if (o_data !== 32'h00000034) begin mismatched++; $display("[TB] FAIL rst_recover got=%h want=00000034", o_data); end
    endtask

    task automatic test_exclusive();
        compared++;
        if (both_count !== 0) begin mismatched++; $display("[TB] FAIL stb_err_overlap got=%0d want=0", both_count); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        stb_count  = 0;
        err_count  = 0;
        both_count = 0;
        test_reset();
        test_basic_line();
        test_back_to_back();
        test_overflow();
        test_malformed();
        test_timeout();
        test_reset_midline();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
